draw_field_frame_ctrl: RTL and testbench

//  Sits between game logic and draw_field. Owns the game_data_t that draw_field

---
 rtl/draw_field_frame_ctrl_pkg.sv | 24 ++
 rtl/draw_field_frame_ctrl_if.sv | 23 ++
 rtl/draw_field_frame_ctrl_tick_div.sv | 28 ++
 rtl/draw_field_frame_ctrl.sv | 113 +++++++++++
 tb/tb_draw_field_frame_ctrl.sv | 139 +++++++++++++
 5 files changed

// File: rtl/draw_field_frame_ctrl_pkg.sv
// Shared draw-side types: field geometry, colour indices, controller state codes
// and the game_data_t image handed to draw_field.
package tetris_draw_pkg;
  localparam int FIELD_ROW_CNT     = 20;
  localparam int FIELD_COL_CNT     = 10;
  localparam int TETRIS_COLORS_CNT = 8;
  localparam int COLOR_W           = $clog2(TETRIS_COLORS_CNT);

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t DEF_FLASH_COLOR   = color_t'(7);
  localparam color_t DEF_CURTAIN_COLOR = color_t'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FLASH   = 2'd1;
  localparam logic [1:0] ST_CURTAIN = 2'd2;

  // field[r][c], row 0 = top
  typedef struct packed {
    logic [FIELD_ROW_CNT-1:0][FIELD_COL_CNT-1:0][COLOR_W-1:0] field;
    logic [2:0]  next_block;
    logic [15:0] score;
  } game_data_t;
endpackage

// File: rtl/draw_field_frame_ctrl_if.sv
// Game-logic <-> frame controller bus; slave is the controller side.
interface draw_field_frame_ctrl_if;
  import tetris_draw_pkg::*;
  logic                     frame_start_i;
  game_data_t               game_data_i;
  logic                     game_data_val_i;
  logic                     flash_req_i;
  logic [FIELD_ROW_CNT-1:0] flash_rows_i;
  logic                     flash_ready_o;
  logic                     flash_done_o;
  logic                     game_over_i;
  logic                     curtain_done_o;
  game_data_t               game_data_o;

  modport slave (
    input  frame_start_i, game_data_i, game_data_val_i, flash_req_i, flash_rows_i, game_over_i,
    output flash_ready_o, flash_done_o, curtain_done_o, game_data_o
  );
  modport master (
    output frame_start_i, game_data_i, game_data_val_i, flash_req_i, flash_rows_i, game_over_i,
    input  flash_ready_o, flash_done_o, curtain_done_o, game_data_o
  );
endinterface

// File: rtl/draw_field_frame_ctrl_tick_div.sv
// Frame divider: combinational tick on the frame pulse that completes each group of N frames.
module frame_tick_div #(
  parameter int N = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic frame_i,
  output logic tick_o
);
  localparam int W = $clog2(N + 1);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = frame_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (frame_i) cnt_d = tick_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/draw_field_frame_ctrl.sv
// Frame-synchronous owner of the draw_field image; applies row-flash and
// game-over curtain overlays only at frame boundaries.
module draw_field_frame_ctrl import tetris_draw_pkg::*; #(
  parameter int     FLASH_FRAMES   = 8,
  parameter int     FLASH_PHASES   = 6,
  parameter int     CURTAIN_FRAMES = 3,
  parameter color_t FLASH_COLOR    = DEF_FLASH_COLOR,
  parameter color_t CURTAIN_COLOR  = DEF_CURTAIN_COLOR
) (
  input logic clk_i,
  input logic rst_i,
  draw_field_frame_ctrl_if.slave bus
);
  localparam int PW = $clog2(FLASH_PHASES + 1);
  localparam int RW = $clog2(FIELD_ROW_CNT + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(FLASH_PHASES - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(FIELD_ROW_CNT);

  logic [1:0]               state_q, state_d;
  logic [PW-1:0]            phase_q, phase_d;
  logic [FIELD_ROW_CNT-1:0] rows_q, rows_d;
  logic [RW-1:0]            row_cnt_q, row_cnt_d;
  logic                     curt_done_q, done_c;
  game_data_t               shadow_q, front_q, ovl;
  logic in_flash, in_curt, flash_tick, curt_tick, flash_end, flash_vis, curt_vis;

  assign in_flash  = (state_q == ST_FLASH);
  assign in_curt   = (state_q == ST_CURTAIN);
  assign flash_end = flash_tick && (phase_q == PH_LAST);
  assign flash_vis = in_flash && !bus.game_over_i && !flash_end;
  assign curt_vis  = in_curt && bus.game_over_i;

  frame_tick_div #(.N(FLASH_FRAMES)) u_flash_div (
    .clk_i, .rst_i, .clr_i(!in_flash || bus.game_over_i),
    .frame_i(bus.frame_start_i), .tick_o(flash_tick)
  );
  frame_tick_div #(.N(CURTAIN_FRAMES)) u_curt_div (
    .clk_i, .rst_i, .clr_i(!curt_vis),
    .frame_i(bus.frame_start_i), .tick_o(curt_tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rows_d    = rows_q;
    row_cnt_d = row_cnt_q;
    done_c    = 1'b0;
    if (bus.game_over_i && !in_curt) begin
      state_d   = ST_CURTAIN;
      row_cnt_d = '0;
      phase_d   = '0;
      done_c    = in_flash;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.flash_req_i) begin
          state_d = ST_FLASH;
          rows_d  = bus.flash_rows_i;
          phase_d = '0;
        end
        ST_FLASH: if (flash_end) begin
          state_d = ST_IDLE;
          phase_d = '0;
          done_c  = 1'b1;
        end else if (flash_tick) begin
          phase_d = phase_q + PW'(1);
        end
        ST_CURTAIN: if (!bus.game_over_i) begin
          state_d   = ST_IDLE;
          row_cnt_d = '0;
        end else if (curt_tick && row_cnt_q != ROW_FULL) begin
          row_cnt_d = row_cnt_q + RW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Curtain uses the post-step row count so the frame that advances it shows it.
  always_comb begin
    ovl = bus.game_data_val_i ? bus.game_data_i : shadow_q;
    for (int r = 0; r < FIELD_ROW_CNT; r++) begin
      if (flash_vis && rows_q[r])
        ovl.field[r] = phase_q[0] ? '0 : {FIELD_COL_CNT{FLASH_COLOR}};
      if (curt_vis && (r + int'(row_cnt_d) >= FIELD_ROW_CNT))
        ovl.field[r] = {FIELD_COL_CNT{CURTAIN_COLOR}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      shadow_q    <= '0;
      front_q     <= '0;
      curt_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rows_q      <= rows_d;
      row_cnt_q   <= row_cnt_d;
      curt_done_q <= (state_d == ST_CURTAIN) && (row_cnt_d == ROW_FULL);
      if (bus.game_data_val_i) shadow_q <= bus.game_data_i;
      if (bus.frame_start_i)   front_q  <= ovl;
    end
  end

  assign bus.flash_ready_o  = (state_q == ST_IDLE);
  assign bus.flash_done_o   = done_c && !rst_i;
  assign bus.curtain_done_o = curt_done_q;
  assign bus.game_data_o    = front_q;
endmodule

// File: tb/tb_draw_field_frame_ctrl.sv
// Directed bench for draw_field_frame_ctrl: shadow/front, bypass, flash, curtain, reset.
module tb_draw_field_frame_ctrl;
  import tetris_draw_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_chk = 0, n_pass = 0, done_cnt = 0;
  game_data_t gd;

  always #5 clk_i = ~clk_i;

  draw_field_frame_ctrl_if bus();

  draw_field_frame_ctrl #(.FLASH_FRAMES(2), .FLASH_PHASES(4), .CURTAIN_FRAMES(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );

  always @(negedge clk_i) if (bus.flash_done_o) done_cnt++;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int fld(input int r, input int c);
    return int'(bus.game_data_o.field[r][c]);
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic frame();
    bus.frame_start_i = 1'b1;
    tick();
    bus.frame_start_i = 1'b0;
  endtask

  initial begin
    int ex;
    rst_i = 1'b1;
    bus.frame_start_i = 0; bus.game_data_i = '0; bus.game_data_val_i = 0;
    bus.flash_req_i = 0; bus.flash_rows_i = '0; bus.game_over_i = 0;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_front", int'(|bus.game_data_o), 0);
    chk("rst_ready", int'(bus.flash_ready_o), 1);
    chk("rst_done", int'(bus.flash_done_o), 0);
    chk("rst_curt", int'(bus.curtain_done_o), 0);

    // shadow only reaches the front on a frame boundary
    gd = '0; gd.field[5][3] = 3'd2; gd.next_block = 3'd5;
    bus.game_data_i = gd; bus.game_data_val_i = 1; tick();
    bus.game_data_val_i = 0; tick();
    chk("shadow_hold", fld(5, 3), 0);
    frame();
    chk("front_upd", fld(5, 3), 2);
    chk("next_block", int'(bus.game_data_o.next_block), 5);

    // bypass
    gd.field[0][0] = 3'd4; bus.game_data_i = gd;
    bus.game_data_val_i = 1; frame(); bus.game_data_val_i = 0;
    chk("bypass", fld(0, 0), 4);
    chk("bypass_keep", fld(5, 3), 2);

    // flash rows 0,1; request coincides with a frame that must not count
    gd = '0; gd.field[5][3] = 3'd2; gd.field[2][0] = 3'd3;
    bus.game_data_i = gd; bus.game_data_val_i = 1; tick(); bus.game_data_val_i = 0;
    bus.flash_rows_i = 20'h3; bus.flash_req_i = 1; frame(); bus.flash_req_i = 0;
    chk("fl_ready_lo", int'(bus.flash_ready_o), 0);
    chk("fl_req_frame", fld(0, 0), 0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        bus.flash_rows_i = 20'h4; bus.flash_req_i = 1; tick(); bus.flash_req_i = 0;
      end
      frame();
      ex = ((((i - 1) / 2) % 2) == 0) ? 7 : 0;
      chk($sformatf("fl_r0_f%0d", i), fld(0, 0), ex);
      chk($sformatf("fl_r1_f%0d", i), fld(1, 9), ex);
      chk($sformatf("fl_r2_f%0d", i), fld(2, 0), 3);
      if (i == 7) chk("fl_no_early_done", done_cnt, 0);
      tick();
    end
    chk("fl_done_once", done_cnt, 1);
    chk("fl_ready_hi", int'(bus.flash_ready_o), 1);

    // game over aborts flash in phase 1
    bus.flash_rows_i = 20'h1; bus.flash_req_i = 1; tick(); bus.flash_req_i = 0;
    frame();
    chk("ab_on", fld(0, 0), 7);
    tick(); frame(); tick();
    bus.game_over_i = 1; #1;
    chk("ab_done_now", int'(bus.flash_done_o), 1);
    tick();
    chk("ab_ready_lo", int'(bus.flash_ready_o), 0);
    for (int k = 1; k <= 60; k++) begin
      frame();
      if (k == 2)  chk("cu_k2_bot", fld(19, 0), 0);
      if (k == 3)  begin chk("cu_k3_bot", fld(19, 0), 1); chk("cu_k3_r18", fld(18, 0), 0); end
      if (k == 30) begin
        chk("cu_k30_r10", fld(10, 0), 1); chk("cu_k30_r9", fld(9, 0), 0);
        chk("cu_k30_r5", fld(5, 3), 2);
      end
      if (k == 59) chk("cu_k59_done", int'(bus.curtain_done_o), 0);
      if (k == 60) begin
        chk("cu_k60_done", int'(bus.curtain_done_o), 1);
        chk("cu_k60_top", fld(0, 0), 1); chk("cu_k60_r5", fld(5, 3), 1);
      end
      tick();
    end
    chk("ab_done_cnt", done_cnt, 2);
    bus.game_over_i = 0; tick();
    chk("cu_exit_ready", int'(bus.flash_ready_o), 1);
    chk("cu_exit_done", int'(bus.curtain_done_o), 0);
    frame();
    chk("cu_exit_bot", fld(19, 0), 0);
    chk("cu_exit_r5", fld(5, 3), 2);
    tick();

    // reset mid-curtain
    bus.game_over_i = 1; tick();
    for (int k = 0; k < 4; k++) begin frame(); tick(); end
    chk("rs_pre_bot", fld(19, 0), 1);
    rst_i = 1; bus.game_over_i = 0; tick();
    chk("rs_front", int'(|bus.game_data_o), 0);
    chk("rs_ready", int'(bus.flash_ready_o), 1);
    chk("rs_curt", int'(bus.curtain_done_o), 0);
    chk("rs_done", int'(bus.flash_done_o), 0);
    rst_i = 0; tick();
    frame();
    chk("rs_shadow_clr", int'(|bus.game_data_o), 0);
    chk("rs_no_pulse", done_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
